alien_dive_scheduler: RTL and testbench
=======================================

# alien_dive_scheduler

Sequences the alien dive attacks in the Galaxian game logic. Tracks which of the 12 formation aliens are still alive from the per-alien hit flags, waits a programmable number of frames between dives, picks the next live alien round-robin, and hands it to the dive-path datapath over a request/acknowledge/done handshake. Sits between the collision logic, which produces `alien*_hit`, and the sprite motion logic, which executes the dive.

## Interface
- `N_ALIENS`, 12: number of formation aliens. Fixed at 12 for this design; `dive_id` is 4 bits wide.
- `DIVE_INTERVAL`, 120: number of `frame_tick` pulses between the end of one dive and the start of the next selection. Legal range 1..255.

- `Clk`  in  1  system clock; all state updates on rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `frame_tick`  in  1  one-cycle pulse per video frame.
- `alien_hit`  in  12  bit i high = alien i+1 destroyed this cycle (level; may stay high).
- `wave_restart`  in  1  one-cycle pulse: new wave, all aliens revived.
- `dive_ack`  in  1  dive datapath accepted the current request.
- `dive_done`  in  1  one-cycle pulse: diving alien returned to formation.
- `dive_req`  out  1  request a dive for `dive_id`.
- `dive_id`  out  4  index 0..11 of the alien selected to dive.
- `diving`  out  1  high from acknowledge until the dive ends.
- `alive_mask`  out  12  registered live-alien mask; bit i = alien i+1.
- `alive_count`  out  4  population count of `alive_mask`, 0..12.
- `wave_clear`  out  1  high while `alive_mask` == 0.

## Operation
- The FSM has five states: WAIT, SELECT, REQ, DIVE, CLEARED.
- **Next mask.** `nmask = alive_mask & ~alien_hit`.
  - `alive_mask <= nmask` every cycle.
  - A dead bit stays cleared until `Reset` or `wave_restart`.
- **WAIT.**
  - The interval counter decrements once per `frame_tick`.
  - When the counter is 1 and `frame_tick` is high, go to SELECT.
  - If `nmask` == 0, go to CLEARED.
- **SELECT (one cycle).**
  - Search `nmask` round-robin, starting at `(last_id+1) mod 12` and wrapping 11→0.
  - Register the first set index into `dive_id` and `last_id`, then go to REQ.
  - If `nmask` == 0, go to CLEARED instead.
  - A just-hit alien is never selected.
- **REQ.**
  - `dive_req` = 1 and `dive_id` is held stable.
  - On `dive_ack`, go to DIVE.
  - If `alien_hit[dive_id]` is high, drop the request and go to WAIT, even if `dive_ack` is high in the same cycle.
- **DIVE.**
  - `diving` = 1.
  - On `dive_done`, go to WAIT.
  - If `alien_hit[dive_id]` is high, abort to WAIT immediately. A later `dive_done` is ignored.
- **CLEARED.**
  - `wave_clear` = 1. Stay here until `wave_restart` or `Reset`.
- **Counter reload.** On every entry to WAIT, reload the counter to `DIVE_INTERVAL`.
- **Stray inputs.**
  - `dive_ack` outside REQ is ignored.
  - `dive_done` outside DIVE is ignored.
- **`wave_restart`** has the same effect as `Reset`, except that it is a normal input. It wins over simultaneous hits, ack or done.
- **Priority per cycle:** Reset > `wave_restart` > hit on selected alien > ack/done > counter.

## Timing
- Reset values:
  - `alive_mask` = 12'hFFF, `alive_count` = 12
  - `dive_req` = 0, `diving` = 0, `wave_clear` = 0, `dive_id` = 0
  - internal `last_id` = 11, so the first pick is alien 0
  - state = WAIT, counter = `DIVE_INTERVAL`
- All outputs are registered.
- `alive_mask`, `alive_count` and `wave_clear` update one cycle after the `alien_hit` bit is sampled high.
- Latency from the terminal `frame_tick` to `dive_req` is 2 cycles: SELECT on the next edge, REQ on the one after.
- `dive_req` drops on the edge after `dive_ack`; `diving` rises on that same edge.
- `diving` drops on the edge after `dive_done` or after the aborting hit.
- With no hits, dives are spaced exactly `DIVE_INTERVAL` frame ticks, counted from the end of the previous dive.
- `wave_clear` rises one cycle after the last live alien's hit.

## Test plan
- **Reset and first dive.** Assert Reset for 2 cycles, `DIVE_INTERVAL`=2, then apply 2 `frame_tick` pulses. Required: outputs equal their reset values during Reset; `dive_req`=1 with `dive_id`=0 two cycles after the 2nd tick.
- **Round-robin with a gap.** Kill aliens 2 and 3 (hit bits 1 and 2), then complete the dive for id 0 (ack, done). Required: the next `dive_id`=3. After id 11 is reached, the selection wraps to 0.
- **Hit during REQ and during DIVE.** Hit the selected alien while `dive_req`=1. Required: `dive_req`=0 next cycle, state back in WAIT, that id is never selected again. Repeat during DIVE. Required: `diving`=0 next cycle, and a following `dive_done` has no effect.
- **Simultaneous events.** Apply `alien_hit[dive_id]` in the same cycle as `dive_ack`. Required: the dive is dropped. Apply `wave_restart` in the same cycle as `alien_hit`=12'h001. Required: `alive_mask`=12'hFFF.
- **Wave clear and restart.** Hit all 12 aliens over several cycles. Required: `alive_count` decrements to 0, `wave_clear`=1, no `dive_req` despite frame ticks. Then pulse `wave_restart`. Required: `alive_count`=12, `wave_clear`=0, next dive picks `dive_id`=0.
- **Level-held hits.** Hold `alien_hit` bit 4 high for 10 cycles. Required: `alive_count` decrements by exactly 1.

Source files
------------

// File: rtl/alien_dive_scheduler_if.sv
// Handshake/status bundle between the dive scheduler, the collision logic
// and the sprite-motion dive datapath.
interface alien_dive_scheduler_if;
  logic        frame_tick;
  logic [11:0] alien_hit;
  logic        wave_restart;
  logic        dive_ack;
  logic        dive_done;
  logic        dive_req;
  logic [3:0]  dive_id;
  logic        diving;
  logic [11:0] alive_mask;
  logic [3:0]  alive_count;
  logic        wave_clear;

  modport master (
    input  frame_tick, alien_hit, wave_restart, dive_ack, dive_done,
    output dive_req, dive_id, diving, alive_mask, alive_count, wave_clear
  );

  modport slave (
    output frame_tick, alien_hit, wave_restart, dive_ack, dive_done,
    input  dive_req, dive_id, diving, alive_mask, alive_count, wave_clear
  );
endinterface

// File: rtl/alien_dive_scheduler.sv
// Picks formation aliens round-robin for dive attacks, paced by frame ticks,
// and tracks the surviving population of the wave.
module alien_dive_scheduler #(
  parameter int unsigned DIVE_INTERVAL = 120
) (
  input  logic                   Clk,
  input  logic                   Reset,
  alien_dive_scheduler_if.master bus
);

  localparam int         N_ALIENS = 12;
  localparam logic [7:0] RELOAD   = 8'(DIVE_INTERVAL);

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_SELECT,
    ST_REQ,
    ST_DIVE,
    ST_CLEARED
  } state_t;

  state_t      r_state, w_state_next;
  logic [7:0]  r_count, w_count_next;
  logic [3:0]  r_last_id, r_dive_id;
  logic [11:0] r_alive;
  logic [3:0]  r_alive_count;
  logic        r_wave_clear, r_dive_req, r_diving;

  logic [11:0] w_nmask;
  logic        w_none_alive;
  logic        w_sel_hit;
  logic        w_load_sel;
  logic [3:0]  w_start, w_off, w_pick, w_popcount;
  logic [4:0]  w_sum;
  logic [23:0] w_dbl;
  logic [11:0] w_rot;

  assign w_nmask      = r_alive & ~bus.alien_hit;
  assign w_none_alive = (w_nmask == 12'h000);
  assign w_sel_hit    = bus.alien_hit[r_dive_id];

  // Rotating a doubled mask right by the start index turns the wrap-around
  // search into a plain lowest-set-bit search.
  assign w_start = (r_last_id >= 4'd11) ? 4'd0 : r_last_id + 4'd1;
  assign w_dbl   = {w_nmask, w_nmask};
  assign w_rot   = 12'(w_dbl >> w_start);

  always_comb begin
    w_off = 4'd0;
    for (int k = N_ALIENS - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = 4'(k);
    end
  end

  assign w_sum  = {1'b0, w_start} + {1'b0, w_off};
  assign w_pick = (w_sum >= 5'd12) ? 4'(w_sum - 5'd12) : w_sum[3:0];

  always_comb begin
    w_popcount = 4'd0;
    for (int k = 0; k < N_ALIENS; k++) begin
      w_popcount = w_popcount + 4'(w_nmask[k]);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_load_sel   = 1'b0;
    case (r_state)
      ST_WAIT: begin
        if (w_none_alive) begin
          w_state_next = ST_CLEARED;
        end else if (bus.frame_tick) begin
          if (r_count <= 8'd1) w_state_next = ST_SELECT;
          else                 w_count_next = r_count - 8'd1;
        end
      end
      ST_SELECT: begin
        if (w_none_alive) begin
          w_state_next = ST_CLEARED;
        end else begin
          w_state_next = ST_REQ;
          w_load_sel   = 1'b1;
        end
      end
      ST_REQ: begin
        // A hit on the requested alien outranks a same-cycle acknowledge.
        if (w_sel_hit) begin
          w_state_next = ST_WAIT;
          w_count_next = RELOAD;
        end else if (bus.dive_ack) begin
          w_state_next = ST_DIVE;
        end
      end
      ST_DIVE: begin
        if (w_sel_hit || bus.dive_done) begin
          w_state_next = ST_WAIT;
          w_count_next = RELOAD;
        end
      end
      ST_CLEARED: w_state_next = ST_CLEARED;
      default: begin
        w_state_next = ST_WAIT;
        w_count_next = RELOAD;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset || bus.wave_restart) begin
      r_state       <= ST_WAIT;
      r_count       <= RELOAD;
      r_last_id     <= 4'd11;
      r_dive_id     <= 4'd0;
      r_alive       <= 12'hFFF;
      r_alive_count <= 4'd12;
      r_wave_clear  <= 1'b0;
      r_dive_req    <= 1'b0;
      r_diving      <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_count       <= w_count_next;
      if (w_load_sel) begin
        r_dive_id <= w_pick;
        r_last_id <= w_pick;
      end
      r_alive       <= w_nmask;
      r_alive_count <= w_popcount;
      r_wave_clear  <= w_none_alive;
      r_dive_req    <= (w_state_next == ST_REQ);
      r_diving      <= (w_state_next == ST_DIVE);
    end
  end

  assign bus.dive_req    = r_dive_req;
  assign bus.dive_id     = r_dive_id;
  assign bus.diving      = r_diving;
  assign bus.alive_mask  = r_alive;
  assign bus.alive_count = r_alive_count;
  assign bus.wave_clear  = r_wave_clear;

endmodule

// File: tb/tb_alien_dive_scheduler.sv
// Directed plus randomized checks of the dive scheduler against a
// frame-level behavioural model.
module tb_alien_dive_scheduler;

  localparam int INTV = 2;
  localparam int P_WAIT = 0, P_SELECT = 1, P_REQ = 2, P_DIVE = 3, P_CLEARED = 4;

  logic Clk;
  logic Reset;
  alien_dive_scheduler_if bus ();

  alien_dive_scheduler #(.DIVE_INTERVAL(INTV)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.master)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model
  logic [11:0] m_alive;
  int          m_phase, m_frames, m_last, m_id;

  task automatic model_step();
    logic [11:0] nm;
    if (Reset || bus.wave_restart) begin
      m_alive  = 12'hFFF;
      m_phase  = P_WAIT;
      m_frames = INTV;
      m_last   = 11;
      m_id     = 0;
      return;
    end
    nm = m_alive & ~bus.alien_hit;
    case (m_phase)
      P_WAIT: begin
        if (nm == 0) m_phase = P_CLEARED;
        else if (bus.frame_tick) begin
          if (m_frames == 1) m_phase = P_SELECT;
          else m_frames = m_frames - 1;
        end
      end
      P_SELECT: begin
        if (nm == 0) m_phase = P_CLEARED;
        else begin
          for (int k = 1; k <= 12; k++) begin
            int c;
            c = (m_last + k) % 12;
            if (nm[c]) begin
              m_id = c;
              m_last = c;
              break;
            end
          end
          m_phase = P_REQ;
        end
      end
      P_REQ: begin
        if (bus.alien_hit[m_id]) begin
          m_phase = P_WAIT;
          m_frames = INTV;
        end else if (bus.dive_ack) m_phase = P_DIVE;
      end
      P_DIVE: begin
        if (bus.alien_hit[m_id] || bus.dive_done) begin
          m_phase = P_WAIT;
          m_frames = INTV;
        end
      end
      default: ;
    endcase
    m_alive = nm;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("dive_req",    16'(bus.dive_req),    16'(m_phase == P_REQ));
    chk("diving",      16'(bus.diving),      16'(m_phase == P_DIVE));
    chk("dive_id",     16'(bus.dive_id),     16'(m_id));
    chk("alive_mask",  16'(bus.alive_mask),  16'(m_alive));
    chk("alive_count", 16'(bus.alive_count), 16'($countones(m_alive)));
    chk("wave_clear",  16'(bus.wave_clear),  16'(m_alive == 12'h000));
  endtask

  task automatic cyc();
    @(posedge Clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic run_to_req();
    for (int i = 0; i < 40 && !bus.dive_req; i++) begin
      bus.frame_tick = (i % 2 == 0);
      cyc();
    end
    bus.frame_tick = 1'b0;
    chk("req_reached", 16'(bus.dive_req), 16'd1);
  endtask

  task automatic complete_dive();
    bus.dive_ack = 1'b1;
    cyc();
    bus.dive_ack = 1'b0;
    bus.dive_done = 1'b1;
    cyc();
    bus.dive_done = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    bus.frame_tick = 1'b0;
    bus.alien_hit = 12'h000;
    bus.wave_restart = 1'b0;
    bus.dive_ack = 1'b0;
    bus.dive_done = 1'b0;

    // Reset values
    cyc();
    cyc();
    chk("rst_req",   16'(bus.dive_req),    16'd0);
    chk("rst_dive",  16'(bus.diving),      16'd0);
    chk("rst_clear", 16'(bus.wave_clear),  16'd0);
    chk("rst_id",    16'(bus.dive_id),     16'd0);
    chk("rst_mask",  16'(bus.alive_mask),  16'hFFF);
    chk("rst_count", 16'(bus.alive_count), 16'd12);
    Reset = 1'b0;

    // First dive: two ticks, request two cycles after the second
    bus.frame_tick = 1'b1; cyc();
    bus.frame_tick = 1'b0; cyc();
    bus.frame_tick = 1'b1; cyc();
    bus.frame_tick = 1'b0;
    chk("sel_no_req_yet", 16'(bus.dive_req), 16'd0);
    cyc();
    chk("first_req", 16'(bus.dive_req), 16'd1);
    chk("first_id",  16'(bus.dive_id),  16'd0);

    // Round-robin skipping dead aliens, then wrap to 0
    bus.alien_hit = 12'h006; cyc(); bus.alien_hit = 12'h000;
    bus.dive_ack = 1'b1; cyc(); bus.dive_ack = 1'b0;
    chk("ack_diving", 16'(bus.diving),   16'd1);
    chk("ack_noreq",  16'(bus.dive_req), 16'd0);
    bus.dive_done = 1'b1; cyc(); bus.dive_done = 1'b0;
    chk("done_diving", 16'(bus.diving), 16'd0);
    run_to_req();
    chk("rr_gap_id", 16'(bus.dive_id), 16'd3);
    for (int e = 4; e <= 12; e++) begin
      complete_dive();
      run_to_req();
      chk("rr_id", 16'(bus.dive_id), 16'(e % 12));
    end

    // Hit during REQ (id 0), then hit during DIVE (id 3)
    bus.alien_hit = 12'h001; cyc(); bus.alien_hit = 12'h000;
    chk("req_hit_drop", 16'(bus.dive_req), 16'd0);
    run_to_req();
    chk("after_req_hit_id", 16'(bus.dive_id), 16'd3);
    bus.dive_ack = 1'b1; cyc(); bus.dive_ack = 1'b0;
    bus.alien_hit = 12'h008; cyc(); bus.alien_hit = 12'h000;
    chk("dive_hit_abort", 16'(bus.diving), 16'd0);
    bus.dive_done = 1'b1; cyc(); bus.dive_done = 1'b0;
    chk("stray_done", 16'(bus.diving), 16'd0);
    run_to_req();
    chk("after_dive_hit_id", 16'(bus.dive_id), 16'd4);

    // Hit and ack together; restart and hit together
    bus.alien_hit = 12'h010; bus.dive_ack = 1'b1; cyc();
    bus.alien_hit = 12'h000; bus.dive_ack = 1'b0;
    chk("hit_ack_nodive", 16'(bus.diving),   16'd0);
    chk("hit_ack_noreq",  16'(bus.dive_req), 16'd0);
    bus.wave_restart = 1'b1; bus.alien_hit = 12'h001; cyc();
    bus.wave_restart = 1'b0; bus.alien_hit = 12'h000;
    chk("restart_mask", 16'(bus.alive_mask), 16'hFFF);

    // Level-held hit counts once
    bus.alien_hit = 12'h010;
    for (int i = 0; i < 10; i++) cyc();
    bus.alien_hit = 12'h000; cyc();
    chk("held_hit_count", 16'(bus.alive_count), 16'd11);

    // Kill the whole wave while ticks keep arriving
    for (int i = 0; i < 12; i++) begin
      bus.alien_hit = 12'h001 << i;
      bus.frame_tick = (i % 2 == 0);
      cyc();
    end
    bus.alien_hit = 12'h000; bus.frame_tick = 1'b0; cyc();
    chk("clear_count", 16'(bus.alive_count), 16'd0);
    chk("clear_flag",  16'(bus.wave_clear),  16'd1);
    for (int i = 0; i < 10; i++) begin
      bus.frame_tick = (i % 2 == 0);
      cyc();
      chk("clear_noreq", 16'(bus.dive_req), 16'd0);
    end
    bus.frame_tick = 1'b0;
    bus.wave_restart = 1'b1; cyc(); bus.wave_restart = 1'b0;
    chk("restart_count", 16'(bus.alive_count), 16'd12);
    chk("restart_clear", 16'(bus.wave_clear),  16'd0);
    run_to_req();
    chk("restart_id", 16'(bus.dive_id), 16'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      Reset            = ($urandom_range(0, 499) == 0);
      bus.wave_restart = ($urandom_range(0, 299) == 0);
      bus.frame_tick   = ($urandom_range(0, 2) == 0);
      bus.dive_ack     = ($urandom_range(0, 1) == 0);
      bus.dive_done    = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0)
        bus.alien_hit = 12'h001 << $urandom_range(0, 11);
      else
        bus.alien_hit = 12'h000;
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
